lobster_cache_ctrl: RTL and testbench

Request front-end sitting directly upstream of lobster_cache.
- Accepts read, write and find requests over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each request onto the cache's single-cycle strobe interface (we/find/addr_in/data_in/addr_out).
- Captures the cache's registered data_out one cycle after issue and returns it over a valid/ready response channel.
- Hides the cache's fixed 1-cycle read latency and its lack of a ready signal from the core.

---
 rtl/lobster_cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_lobster_cache_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lobster_cache_ctrl.sv
// lobster_cache_ctrl: request front-end for lobster_cache.
// Buffers read/write/find requests in a small FIFO. Each request is issued
// to the cache as a one-cycle strobe. The cache's registered data_out is
// captured and returned on a valid/ready response channel.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_*            request channel (valid/ready, op, addr, data)
//   rsp_*            response channel (valid/ready, op, data, hit)
//   cache_*          strobe interface to lobster_cache
// Optional build macro LOBSTER_CACHE_CTRL_STATS_EN adds four 32-bit
// counters: stat_reads, stat_writes, stat_finds and stat_misses.
module lobster_cache_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_op,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  cache_we,
  output logic                  cache_find,
  output logic [ADDR_WIDTH-1:0] cache_addr_in,
  output logic [DATA_WIDTH-1:0] cache_data_in,
  output logic [ADDR_WIDTH-1:0] cache_addr_out,
  input  logic [DATA_WIDTH-1:0] cache_data_out
`ifdef LOBSTER_CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_finds,
  output logic [31:0]           stat_misses
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FIND  = 2'b10;

  typedef struct packed {
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t           state_q, state_d;
  req_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  req_t             iss_q;

  logic                  rsp_valid_q, rsp_hit_q;
  logic [1:0]            rsp_op_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic full, empty, push, pop;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state_q == S_IDLE) && !empty;

  // Request FIFO storage and pointers; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{op: req_op, addr: req_addr, data: req_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      iss_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        iss_q    <= fifo_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; only read and find wait for cache data
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = ((iss_q.op == OP_READ) || (iss_q.op == OP_FIND)) ? S_CAPTURE : S_IDLE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Cache strobes: only in ISSUE, never during the reset cycle
  always_comb begin
    cache_we       = 1'b0;
    cache_find     = 1'b0;
    cache_addr_in  = '0;
    cache_data_in  = '0;
    cache_addr_out = '0;
    if ((state_q == S_ISSUE) && !rst) begin
      case (iss_q.op)
        OP_WRITE: begin
          cache_we      = 1'b1;
          cache_addr_in = iss_q.addr;
          cache_data_in = iss_q.data;
        end
        OP_READ:  cache_addr_out = iss_q.addr;
        OP_FIND: begin
          cache_find    = 1'b1;
          cache_data_in = iss_q.data;
        end
        default: ;
      endcase
    end
  end

  // Response registers: captured in CAPTURE, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
    end else if (state_q == S_CAPTURE) begin
      rsp_valid_q <= 1'b1;
      rsp_op_q    <= iss_q.op;
      rsp_data_q  <= cache_data_out;
      rsp_hit_q   <= (iss_q.op == OP_FIND) ? !cache_data_out[DATA_WIDTH-1] : 1'b1;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;

`ifdef LOBSTER_CACHE_CTRL_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_finds_q, stat_misses_q;
  logic        iss_rd, iss_wr, iss_fd, cap_miss;

  assign iss_rd   = (state_q == S_ISSUE) && (iss_q.op == OP_READ);
  assign iss_wr   = (state_q == S_ISSUE) && (iss_q.op == OP_WRITE);
  assign iss_fd   = (state_q == S_ISSUE) && (iss_q.op == OP_FIND);
  assign cap_miss = (state_q == S_CAPTURE) && (iss_q.op == OP_FIND) && cache_data_out[DATA_WIDTH-1];

  // Activity counters; wrap at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_finds_q  <= '0;
      stat_misses_q <= '0;
    end else begin
      if (iss_rd) begin
        stat_reads_q <= stat_reads_q + 32'd1;
        $display("%m: stat_reads=%0d", stat_reads_q + 32'd1);
      end
      if (iss_wr) begin
        stat_writes_q <= stat_writes_q + 32'd1;
        $display("%m: stat_writes=%0d", stat_writes_q + 32'd1);
      end
      if (iss_fd) begin
        stat_finds_q <= stat_finds_q + 32'd1;
        $display("%m: stat_finds=%0d", stat_finds_q + 32'd1);
      end
      if (cap_miss) begin
        stat_misses_q <= stat_misses_q + 32'd1;
        $display("%m: stat_misses=%0d", stat_misses_q + 32'd1);
      end
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_finds  = stat_finds_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_lobster_cache_ctrl.sv
// Directed bench for lobster_cache_ctrl with a small behavioural cache:
// 16 slots indexed by addr[5:2], registered data_out, find returns the
// slot index or 0x80000000 when the value is absent.
module tb_lobster_cache_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_hit;
  logic [1:0]    rsp_op;
  logic [DW-1:0] rsp_data;
  logic          cache_we, cache_find;
  logic [AW-1:0] cache_addr_in, cache_addr_out;
  logic [DW-1:0] cache_data_in, cache_data_out;

  always #5 clk = ~clk;

  lobster_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .cache_we(cache_we), .cache_find(cache_find),
    .cache_addr_in(cache_addr_in), .cache_data_in(cache_data_in),
    .cache_addr_out(cache_addr_out), .cache_data_out(cache_data_out)
  );

  // Behavioural cache
  logic [DW-1:0] cmem [16];
  logic          cval [16];
  initial begin
    for (int i = 0; i < 16; i++) begin cmem[i] = '0; cval[i] = 1'b0; end
    cache_data_out = '0;
  end
  always @(posedge clk) begin : cache_model
    logic [DW-1:0] r;
    if (cache_we) begin
      cmem[cache_addr_in[5:2]] <= cache_data_in;
      cval[cache_addr_in[5:2]] <= 1'b1;
    end
    if (cache_find) begin
      r = 32'h8000_0000;
      for (int i = 15; i >= 0; i--)
        if (cval[i] && (cmem[i] == cache_data_in)) r = 32'(i);
      cache_data_out <= r;
    end else begin
      cache_data_out <= cval[cache_addr_out[5:2]] ? cmem[cache_addr_out[5:2]] : '0;
    end
  end

  // Monitors
  int          cyc = 0;
  int          rsp_total = 0;
  int          strobe_cnt = 0;
  int          we_cnt = 0;
  logic [34:0] got [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cache_we || cache_find) strobe_cnt <= strobe_cnt + 1;
    if (cache_we) we_cnt <= we_cnt + 1;
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_total <= rsp_total + 1;
      got.push_back({rsp_op, rsp_hit, rsp_data});
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Present one request; returns the cycle stamp of its accepting edge
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout("send");
      req_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_rsp;
    logic [1:0]  exp_op;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acc, n, s0, r0, w0;
    logic [34:0] exp_q [$];

    vecs[0] = '{2'b01, 32'h10, 32'hDEADBEEF, 1'b0, 2'b00, 32'h0,         1'b0};
    vecs[1] = '{2'b00, 32'h10, 32'h0,        1'b1, 2'b00, 32'hDEADBEEF,  1'b1};
    vecs[2] = '{2'b10, 32'h0,  32'hDEADBEEF, 1'b1, 2'b10, 32'h4,         1'b1};
    vecs[3] = '{2'b10, 32'h0,  32'h12345678, 1'b1, 2'b10, 32'h80000000,  1'b0};
    vecs[4] = '{2'b01, 32'h24, 32'h0BADF00D, 1'b0, 2'b00, 32'h0,         1'b0};
    vecs[5] = '{2'b00, 32'h24, 32'h0,        1'b1, 2'b00, 32'h0BADF00D,  1'b1};
    vecs[6] = '{2'b10, 32'h0,  32'h0BADF00D, 1'b1, 2'b10, 32'h9,         1'b1};
    vecs[7] = '{2'b11, 32'h10, 32'h55555555, 1'b0, 2'b00, 32'h0,         1'b0};
    vecs[8] = '{2'b00, 32'h10, 32'h0,        1'b1, 2'b00, 32'hDEADBEEF,  1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1;
    idle(2);
    chk("rst_cache_we",   35'(cache_we),   35'(0));
    chk("rst_cache_find", 35'(cache_find), 35'(0));
    rst = 1'b0;
    idle(1);
    chk("rst_rsp_valid", 35'(rsp_valid), 35'(0));
    chk("rst_rsp_data",  35'(rsp_data),  35'(0));
    chk("rst_rsp_op",    35'(rsp_op),    35'(0));
    chk("rst_rsp_hit",   35'(rsp_hit),   35'(0));
    chk("rst_req_ready", 35'(req_ready), 35'(1));

    // Table-driven single transactions
    for (int i = 0; i < 9; i++) begin
      s0 = strobe_cnt; r0 = rsp_total; w0 = we_cnt;
      send(vecs[i].op, vecs[i].addr, vecs[i].data, acc);
      if (vecs[i].exp_rsp) begin
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout($sformatf("vec%0d_rsp", i));
        else begin
          chk($sformatf("vec%0d_latency", i), 35'(cyc - acc), 35'(3));
          chk($sformatf("vec%0d_rsp", i), {rsp_op, rsp_hit, rsp_data},
              {vecs[i].exp_op, vecs[i].exp_hit, vecs[i].exp_data});
        end
        idle(3);
        chk($sformatf("vec%0d_rsp_count", i), 35'(rsp_total - r0), 35'(1));
      end else begin
        idle(6);
        chk($sformatf("vec%0d_no_rsp", i), 35'(rsp_total - r0), 35'(0));
        chk($sformatf("vec%0d_we_count", i), 35'(we_cnt - w0),
            (vecs[i].op == 2'b01) ? 35'(1) : 35'(0));
        if (vecs[i].op == 2'b11)
          chk($sformatf("vec%0d_no_strobe", i), 35'(strobe_cnt - s0), 35'(0));
      end
    end

    // Backpressure: 5 reads while the consumer stalls
    got.delete();
    exp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'b00, (i % 2 == 0) ? 32'h10 : 32'h24, 32'h0, acc);
      exp_q.push_back({2'b00, 1'b1, (i % 2 == 0) ? 32'hDEADBEEF : 32'h0BADF00D});
    end
    idle(4);
    chk("bp_req_ready_low", 35'(req_ready), 35'(0));
    chk("bp_rsp_held", {rsp_valid, rsp_data}, {1'b1, 32'hDEADBEEF});
    chk("bp_no_early_rsp", 35'(got.size()), 35'(0));
    rsp_ready = 1'b1;
    n = 0;
    while (got.size() < 5 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("bp_drain");
    idle(10);
    chk("bp_rsp_count", 35'(got.size()), 35'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("bp_rsp%0d", i), got[i], exp_q[i]);
      else timeout($sformatf("bp_rsp%0d", i));
    end
    chk("bp_req_ready_back", 35'(req_ready), 35'(1));

    // Reset while a response is held and two requests are queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b00, 32'h10, 32'h0, acc);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("rst_mid_wait");
    r0 = rsp_total; w0 = we_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rsp_valid", 35'(rsp_valid), 35'(0));
    chk("rstmid_req_ready", 35'(req_ready), 35'(1));
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(12);
    chk("rstmid_no_stale", 35'(rsp_total - r0), 35'(0));
    chk("rstmid_no_we", 35'(we_cnt - w0), 35'(0));
    chk("rstmid_rsp_valid_after", 35'(rsp_valid), 35'(0));

    // Controller still works after the mid-operation reset
    send(2'b00, 32'h24, 32'h0, acc);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("post_rst_read");
    else chk("post_rst_read", {rsp_op, rsp_hit, rsp_data}, {2'b00, 1'b1, 32'h0BADF00D});
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
